// File: rtl/data_mem_pipe.sv
// Parametrised data memory with a registered read port and a valid/ready request handshake.
// After reset an optional hardware sweep zeroes the array; accesses at or beyond DEPTH are flagged.
module data_mem_pipe #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] data_out,
    output logic              init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t          RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    // One extra counter bit lets DEPTH = 2**ADDR_W be represented without wrapping.
    localparam logic [ADDR_W:0] DEPTH_L     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX    = (ADDR_W + 1)'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W:0]   r_clr_cnt;
    logic [ADDR_W:0]   w_next_clr_cnt;
    logic              r_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic              r_init_done;
    logic [DATA_W-1:0] r_data_out;

    logic              w_accept;
    logic              w_in_range;
    logic              w_rd_accept;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    always_comb begin
        w_next_state   = r_state;
        w_next_clr_cnt = r_clr_cnt;
        w_mem_we       = 1'b0;
        w_mem_addr     = addr_in;
        w_mem_wdata    = data_in;
        w_in_range     = ({1'b0, addr_in} < DEPTH_L);
        w_accept       = req_valid & r_ready;
        w_rd_accept    = w_accept & ~req_write;

        case (r_state)
            ST_INIT: begin
                w_mem_we       = 1'b1;
                w_mem_addr     = r_clr_cnt[ADDR_W-1:0];
                w_mem_wdata    = '0;
                w_next_clr_cnt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == LAST_IDX) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // Out-of-range writes are dropped; only the error pulse records them.
                w_mem_we = w_accept & req_write & w_in_range;
            end
            default: begin
                w_next_state = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= RESET_STATE;
            r_clr_cnt    <= '0;
            r_ready      <= 1'b0;
            r_init_done  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_clr_cnt    <= w_next_clr_cnt;
            r_ready      <= (w_next_state == ST_RUN);
            r_init_done  <= (w_next_state == ST_RUN);
            r_resp_valid <= w_rd_accept;
            r_resp_err   <= w_accept & ~w_in_range;
            if (w_rd_accept) begin
                r_data_out <= w_in_range ? r_mem[w_mem_addr] : '0;
            end
        end
    end

    // The array itself has no reset; the INIT sweep is what clears it.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign data_out   = r_data_out;
    assign init_done  = r_init_done;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Drives a full-depth and a DEPTH=200 instance with shared requests and checks both
// against array-based reference models.
module tb_data_mem_pipe;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       reqValid;
    logic       reqWrite;
    logic [7:0] addrIn;
    logic [7:0] dataIn;

    logic       aReady, aRespValid, aRespErr, aInitDone;
    logic [7:0] aDataOut;
    logic       bReady, bRespValid, bRespErr, bInitDone;
    logic [7:0] bDataOut;

    int testCount = 0;
    int failCount = 0;

    logic [7:0] modelA [256];
    logic [7:0] modelB [200];
    logic [7:0] expDoutA;
    logic [7:0] expDoutB;

    always #5 CLK = ~CLK;

    data_mem_pipe #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .CLEAR_ON_RESET(1'b1)) dutA (
        .CLK(CLK), .RST_N(RST_N), .req_valid(reqValid), .req_ready(aReady),
        .req_write(reqWrite), .addr_in(addrIn), .data_in(dataIn),
        .resp_valid(aRespValid), .resp_err(aRespErr), .data_out(aDataOut),
        .init_done(aInitDone)
    );

    data_mem_pipe #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .CLEAR_ON_RESET(1'b1)) dutB (
        .CLK(CLK), .RST_N(RST_N), .req_valid(reqValid), .req_ready(bReady),
        .req_write(reqWrite), .addr_in(addrIn), .data_in(dataIn),
        .resp_valid(bRespValid), .resp_err(bRespErr), .data_out(bDataOut),
        .init_done(bInitDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearModels();
        for (int i = 0; i < 256; i++) modelA[i] = 8'h00;
        for (int i = 0; i < 200; i++) modelB[i] = 8'h00;
        expDoutA = 8'h00;
        expDoutB = 8'h00;
    endtask

    // One request cycle on both instances, then compare against the models.
    task automatic applyStimulus(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        logic expRvA, expReA, expRvB, expReB;
        logic inB;
        reqValid = v;
        reqWrite = w;
        addrIn   = a;
        dataIn   = d;
        @(posedge CLK);
        #1;
        reqValid = 1'b0;
        inB    = (a < 8'd200);
        expRvA = v & ~w;
        expReA = 1'b0;
        expRvB = v & ~w;
        expReB = v & ~inB;
        if (v && w) begin
            modelA[a] = d;
            if (inB) modelB[a] = d;
        end else if (v) begin
            expDoutA = modelA[a];
            expDoutB = inB ? modelB[a] : 8'h00;
        end
        checkOutput($sformatf("A.resp_valid@%0h", a), 32'(aRespValid), 32'(expRvA));
        checkOutput($sformatf("A.resp_err@%0h", a), 32'(aRespErr), 32'(expReA));
        checkOutput($sformatf("A.data_out@%0h", a), 32'(aDataOut), 32'(expDoutA));
        checkOutput($sformatf("B.resp_valid@%0h", a), 32'(bRespValid), 32'(expRvB));
        checkOutput($sformatf("B.resp_err@%0h", a), 32'(bRespErr), 32'(expReB));
        checkOutput($sformatf("B.data_out@%0h", a), 32'(bDataOut), 32'(expDoutB));
    endtask

    // Releases reset, attempts a write to 0x10 during the sweep, and times ready.
    task automatic measureSweep();
        int readyA = -1;
        int readyB = -1;
        int sawResp = 0;
        RST_N = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            reqValid = (n <= 10);
            reqWrite = 1'b1;
            addrIn   = 8'h10;
            dataIn   = 8'hEE;
            @(posedge CLK);
            #1;
            if (aRespValid || aRespErr || bRespValid || bRespErr) sawResp++;
            if (aReady && readyA < 0) readyA = n;
            if (bReady && readyB < 0) readyB = n;
            if (readyA > 0 && readyB > 0) break;
        end
        reqValid = 1'b0;
        checkOutput("A.sweep_cycles", 32'(readyA), 32'd256);
        checkOutput("B.sweep_cycles", 32'(readyB), 32'd200);
        checkOutput("init_responses", 32'(sawResp), 32'd0);
        checkOutput("A.init_done", 32'(aInitDone), 32'd1);
        checkOutput("B.init_done", 32'(bInitDone), 32'd1);
    endtask

    initial begin
        RST_N    = 1'b0;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        addrIn   = 8'h00;
        dataIn   = 8'h00;
        clearModels();
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst.A.ready", 32'(aReady), 32'd0);
        checkOutput("rst.A.init_done", 32'(aInitDone), 32'd0);
        checkOutput("rst.A.resp_valid", 32'(aRespValid), 32'd0);
        checkOutput("rst.A.data_out", 32'(aDataOut), 32'd0);
        checkOutput("rst.B.ready", 32'(bReady), 32'd0);

        measureSweep();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'd127, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'd255, 8'h00);

        applyStimulus(1'b1, 1'b1, 8'h10, 8'hA5);
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);

        applyStimulus(1'b1, 1'b1, 8'h01, 8'h11);
        applyStimulus(1'b1, 1'b1, 8'h02, 8'h22);
        applyStimulus(1'b1, 1'b1, 8'h03, 8'h33);
        applyStimulus(1'b1, 1'b0, 8'h01, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h02, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h03, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

        applyStimulus(1'b1, 1'b1, 8'd210, 8'hFF);
        applyStimulus(1'b1, 1'b0, 8'd210, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'd199, 8'h5C);
        applyStimulus(1'b1, 1'b0, 8'd199, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'd200, 8'h00);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                          8'($urandom), 8'($urandom));
        end

        applyStimulus(1'b1, 1'b1, 8'h10, 8'h7E);
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);
        RST_N = 1'b0;
        #1;
        checkOutput("midrst.A.resp_valid", 32'(aRespValid), 32'd0);
        checkOutput("midrst.A.init_done", 32'(aInitDone), 32'd0);
        checkOutput("midrst.A.ready", 32'(aReady), 32'd0);
        checkOutput("midrst.A.data_out", 32'(aDataOut), 32'd0);
        checkOutput("midrst.B.resp_valid", 32'(bRespValid), 32'd0);
        checkOutput("midrst.B.init_done", 32'(bInitDone), 32'd0);
        @(posedge CLK);
        #1;
        clearModels();
        measureSweep();
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'd199, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h03, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
- Parametrised successor to the processor's single-cycle data memory.
- Generalised in data width and depth. Read data is registered, and requests use a valid/ready handshake.
- After reset, a hardware clear sweep zeroes the array. Out-of-range accesses are flagged.
- Sits between the datapath load/store stage and the memory array; the controller stalls on `req_ready`.

Parameters:
- `DATA_W`, 8, data word width in bits.
- `ADDR_W`, 8, address width in bits.
- `DEPTH`, 256, number of implemented words. Must satisfy 1 <= `DEPTH` <= 2**`ADDR_W`.
- `CLEAR_ON_RESET`, 1, when 1 the array is zeroed after reset; when 0 there is no clear sweep.

Ports:
- `CLK` input 1: clock, rising edge.
- `RST_N` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request present this cycle.
- `req_ready` output 1: block can accept a request this cycle.
- `req_write` input 1: 1 = write, 0 = read. Sampled on acceptance.
- `addr_in` input `ADDR_W`: request address.
- `data_in` input `DATA_W`: write data.
- `resp_valid` output 1: read response present, one-cycle pulse.
- `resp_err` output 1: the accepted access addressed >= `DEPTH`. One-cycle pulse, for reads and writes.
- `data_out` output `DATA_W`: read data, held between responses.
- `init_done` output 1: clear sweep complete, block operational.

Behaviour:
- Reset values (`RST_N` low, asynchronous):
  - `req_ready`=0, `resp_valid`=0, `resp_err`=0, `data_out`=0, `init_done`=0.
  - State=INIT if `CLEAR_ON_RESET`=1, else RUN. Clear counter=0.
  - Array contents are not reset asynchronously.
- State machine: two states, INIT and RUN.
  - INIT: each cycle writes 0 to `mem[clr_cnt]` and increments `clr_cnt`.
  - When `clr_cnt`=`DEPTH`-1 is written, go to RUN on the next edge and set `init_done`=1.
  - INIT lasts exactly `DEPTH` cycles after reset deassertion.
  - RUN: `req_ready`=1 every cycle. `init_done` stays 1 until reset.
- `req_ready` is a registered signal: 0 throughout INIT, 1 from the first RUN cycle.
  - `req_valid` while `req_ready`=0 is ignored; no state change and no response.
- Acceptance: a request is accepted when `req_valid` & `req_ready` at a rising edge. At most one request per cycle.
- Write, addr < `DEPTH`: `mem[addr_in]` <= `data_in` at the accepting edge. No `resp_valid`.
- Read, addr < `DEPTH`: `data_out` <= `mem[addr_in]` at the accepting edge.
  - `resp_valid`=1 for the following cycle. Latency 1 cycle.
  - Back-to-back reads give back-to-back responses.
- Write then read of the same address on consecutive cycles: the read returns the new data. The array is updated at the write edge.
- Out-of-range (addr >= `DEPTH`):
  - Write is dropped; the array is unchanged.
  - Read sets `data_out`=0 and `resp_valid`=1.
  - Both pulse `resp_err`=1 in the same cycle `resp_valid` would appear.
- Outside responses `resp_valid`=0 and `resp_err`=0; `data_out` holds its last value.
- Reset asserted mid-INIT or mid-RUN:
  - All outputs return to reset values immediately.
  - Any in-flight response is discarded.
  - The sweep restarts at address 0 after deassertion.
- `CLEAR_ON_RESET`=0: RUN, `req_ready`=1 and `init_done`=1 from the first edge after deassertion. Array contents are undefined until written.
- Width rules:
  - `clr_cnt` is `ADDR_W`+1 bits, so `DEPTH`=2**`ADDR_W` terminates without wrap.
  - The address comparison is unsigned.

Test Plan:
- Reset release, defaults: `req_ready`=0 for exactly 256 cycles, then `req_ready`=1 and `init_done`=1. Reading addrs 0, 127, 255 returns 0 each.
- Write 8'hA5 to addr 8'h10, then read 8'h10 the next cycle: `resp_valid` one cycle later, `data_out`=8'hA5, `resp_err`=0.
- Reads of addrs 1, 2, 3 issued back to back, previously written 8'h11/22/33: `resp_valid` high 3 consecutive cycles with 8'h11, 8'h22, 8'h33 in order. `data_out` holds 8'h33 afterwards.
- `DEPTH`=200:
  - Write 8'hFF to addr 210: `resp_err` pulses, no `resp_valid`.
  - Read addr 210: `resp_valid`=1, `resp_err`=1, `data_out`=0.
  - Read addr 199: returns the stored value, `resp_err`=0.
- `RST_N` pulsed low for 1 cycle mid-RUN with a read in flight: `resp_valid` drops immediately and `init_done`=0. Sweep reruns for 256 cycles, then addr 8'h10 reads 0.
- `req_valid`=1 with a write during INIT: ignored. After `init_done`, the target address reads 0.
